muldiv_sequencer: RTL and testbench

Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the Execute stage. It runs shift-add multiply and restoring divide over 32 iterations and borrows the shared 32-bit ALU for the per-iteration add/subtract. Results land in HI/LO. The hazard unit stalls the pipeline while `busy` is high. The Execute-stage operand mux hands ALU inputs to this block whenever `alu_own` is high.

---
 rtl/muldiv_sequencer_if.sv | 48 ++++
 rtl/muldiv_sequencer.sv | 272 +++++++++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer_if
//   Bundle between the Execute stage and the multi-cycle MULT/DIV sequencer.
//   The master side is the pipeline: request fields, flush and the shared ALU
//   return. The slave side is the sequencer: status, HI/LO and the ALU
//   operand/opcode drive.
//
//   start       : request, only looked at while the sequencer is idle
//   op          : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_val      : multiplicand / dividend
//   rt_val      : multiplier / divisor
//   flush       : abort the operation in flight
//   busy        : operation in progress (pipeline stall)
//   done        : one-cycle pulse, HI/LO just updated
//   hi, lo      : architectural HI/LO
//   alu_own     : sequencer drives the shared ALU this cycle
//   alu_a/alu_b : ALU operands
//   alu_control : ALU opcode (010 add, 110 subtract)
//   alu_result  : combinational ALU result
// ---------------------------------------------------------------------------
interface muldiv_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic            alu_own;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [2:0]      alu_control;
  logic [XLEN-1:0] alu_result;

  modport master (
    output start, op, rs_val, rt_val, flush, alu_result,
    input  busy, done, hi, lo, alu_own, alu_a, alu_b, alu_control
  );

  modport slave (
    input  start, op, rs_val, rt_val, flush, alu_result,
    output busy, done, hi, lo, alu_own, alu_a, alu_b, alu_control
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
//   Multi-cycle MULT/MULTU/DIV/DIVU engine for the Execute stage. Multiply is
//   shift-add, divide is restoring; both take 32 iterations and borrow the
//   shared ALU for the per-iteration add/subtract. Signed operations work on
//   magnitudes and fix up signs at the end. Results are written to HI/LO.
//
//   Ports:
//     clk   : clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : muldiv_sequencer_if.slave (request, flush, status, HI/LO, ALU)
//
//   Configuration macro MULDIV_DIV_EN:
//     defined   - all four operations.
//     undefined - divide hardware is not built; DIV/DIVU complete in one
//                 cycle (IDLE -> DONE) with HI=LO=0 and never own the ALU.
// ---------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  muldiv_sequencer_if.slave bus
);

  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [5:0] LAST_ITER = 6'd31;
`ifdef MULDIV_DIV_EN
  localparam logic [2:0] ALU_SUB   = 3'b110;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t          state_reg;
  state_t          state_next;

  logic [XLEN-1:0] acc_hi_reg;
  logic [XLEN-1:0] acc_lo_reg;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [XLEN-1:0] opnd_reg;
  logic [XLEN-1:0] hi_reg;
  logic [XLEN-1:0] lo_reg;
  logic [5:0]      cnt_reg;
  logic            neg_a_reg;
  logic            neg_b_reg;
`ifdef MULDIV_DIV_EN
  logic            is_div_reg;
`endif

  // Operand conditioning (used in PREP)
  logic            is_signed;
  logic            rs_neg;
  logic            rt_neg;
  logic [XLEN-1:0] rs_mag;
  logic [XLEN-1:0] rt_mag;

  always_comb begin
    is_signed = ~bus.op[0];
    rs_neg    = is_signed & bus.rs_val[XLEN-1];
    rt_neg    = is_signed & bus.rt_val[XLEN-1];
    rs_mag    = rs_neg ? (~bus.rs_val + 1'b1) : bus.rs_val;
    rt_mag    = rt_neg ? (~bus.rt_val + 1'b1) : bus.rt_val;
  end

  // ALU drive, computed by the output process and reused by the datapath
  logic [XLEN-1:0] alu_a_c;
  logic [XLEN-1:0] alu_b_c;
  logic [2:0]      alu_control_c;
  logic            alu_own_c;
  logic            busy_c;
  logic            done_c;

  // Unsigned add overflow: result wrapped below the first operand.
  logic            carry;
  assign carry = (bus.alu_result < alu_a_c);

`ifdef MULDIV_DIV_EN
  // Restoring divide step. The partial remainder is always below the
  // divisor, so the shifted value needs 33 bits; ovf is that top bit, and
  // when it is set the subtraction always succeeds and wraps correctly.
  logic [XLEN-1:0] rsh;
  logic            ovf;
  logic            qbit;
  logic            div_zero;

  always_comb begin
    rsh      = {acc_hi_reg[XLEN-2:0], acc_lo_reg[XLEN-1]};
    ovf      = acc_hi_reg[XLEN-1];
    qbit     = ovf | (rsh >= opnd_reg);
    div_zero = bus.op[1] & (bus.rt_val == '0);
  end
`endif

  // Sign fix-up and HI/LO selection (used in FIX)
  logic [2*XLEN-1:0] product;
  logic [2*XLEN-1:0] product_fix;
  logic [XLEN-1:0]   fix_hi;
  logic [XLEN-1:0]   fix_lo;

  always_comb begin
    product     = {acc_hi_reg, acc_lo_reg};
    product_fix = (neg_a_reg ^ neg_b_reg) ? (~product + 1'b1) : product;
    fix_hi      = product_fix[2*XLEN-1:XLEN];
    fix_lo      = product_fix[XLEN-1:0];
`ifdef MULDIV_DIV_EN
    // Quotient negative when signs differ; remainder follows the dividend.
    // INT_MIN / -1 yields 0x80000000 / 0 naturally through this path.
    if (is_div_reg) begin
      fix_hi = neg_a_reg ? (~acc_hi_reg + 1'b1) : acc_hi_reg;
      fix_lo = (neg_a_reg ^ neg_b_reg) ? (~acc_lo_reg + 1'b1) : acc_lo_reg;
    end
`endif
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
`ifdef MULDIV_DIV_EN
          state_next = S_PREP;
`else
          state_next = bus.op[1] ? S_DONE : S_PREP;
`endif
        end
      end
      S_PREP: begin
        if (bus.flush) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_RUN;
`ifdef MULDIV_DIV_EN
          if (div_zero) begin
            state_next = S_DONE;
          end
`endif
        end
      end
      S_RUN: begin
        if (bus.flush) begin
          state_next = S_IDLE;
        end else if (cnt_reg == LAST_ITER) begin
          state_next = S_FIX;
        end
      end
      S_FIX: begin
        state_next = bus.flush ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy_c        = (state_reg != S_IDLE);
    done_c        = (state_reg == S_DONE);
    alu_own_c     = 1'b0;
    alu_a_c       = '0;
    alu_b_c       = '0;
    alu_control_c = 3'b000;
    if (state_reg == S_RUN) begin
      alu_own_c     = 1'b1;
      alu_a_c       = acc_hi_reg;
      alu_b_c       = acc_lo_reg[0] ? opnd_reg : '0;
      alu_control_c = ALU_ADD;
`ifdef MULDIV_DIV_EN
      if (is_div_reg) begin
        alu_a_c       = rsh;
        alu_b_c       = opnd_reg;
        alu_control_c = ALU_SUB;
      end
`endif
    end
  end

  assign bus.busy        = busy_c;
  assign bus.done        = done_c;
  assign bus.alu_own     = alu_own_c;
  assign bus.alu_a       = alu_a_c;
  assign bus.alu_b       = alu_b_c;
  assign bus.alu_control = alu_control_c;
  assign bus.hi          = hi_reg;
  assign bus.lo          = lo_reg;

  // ---------------- Datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hi_reg <= '0;
      acc_lo_reg <= '0;
      opnd_reg   <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      cnt_reg    <= '0;
      neg_a_reg  <= 1'b0;
      neg_b_reg  <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
`ifndef MULDIV_DIV_EN
        S_IDLE: begin
          // Divide not built: a DIV/DIVU request commits zeros directly.
          if (bus.start && !bus.flush && bus.op[1]) begin
            hi_reg <= '0;
            lo_reg <= '0;
          end
        end
`endif
        S_PREP: begin
          neg_a_reg  <= rs_neg;
          neg_b_reg  <= rt_neg;
          acc_hi_reg <= '0;
          cnt_reg    <= '0;
          opnd_reg   <= rs_mag;
          acc_lo_reg <= rt_mag;
`ifdef MULDIV_DIV_EN
          is_div_reg <= bus.op[1];
          if (bus.op[1]) begin
            opnd_reg   <= rt_mag;
            acc_lo_reg <= rs_mag;
          end
          if (div_zero && !bus.flush) begin
            hi_reg <= bus.rs_val;
            lo_reg <= '1;
          end
`endif
        end
        S_RUN: begin
          cnt_reg                  <= cnt_reg + 6'd1;
          {acc_hi_reg, acc_lo_reg} <= {carry, bus.alu_result, acc_lo_reg[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
          if (is_div_reg) begin
            acc_hi_reg <= qbit ? bus.alu_result : rsh;
            acc_lo_reg <= {acc_lo_reg[XLEN-2:0], qbit};
          end
`endif
        end
        S_FIX: begin
          if (!bus.flush) begin
            hi_reg <= fix_hi;
            lo_reg <= fix_lo;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_muldiv_sequencer
//   Directed bench for muldiv_sequencer. Models the shared ALU, launches
//   operations and compares HI/LO, latency, ALU ownership, flush and reset
//   behaviour against hand-computed values. Expectations for DIV/DIVU follow
//   the MULDIV_DIV_EN build option.
// ---------------------------------------------------------------------------
module tb_muldiv_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  muldiv_sequencer_if #(.XLEN(32)) bus ();

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Shared ALU: combinational add/subtract
  assign bus.alu_result = (bus.alu_control == 3'b010) ? (bus.alu_a + bus.alu_b) :
                          (bus.alu_control == 3'b110) ? (bus.alu_a - bus.alu_b) : 32'h0;

  // Launch one operation, follow it to done (bounded), then step into IDLE.
  // lat is the cycle index of done counted from the start edge (-1 = timeout).
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int own, output int busy_n,
                        output logic [31:0] hi_o, output logic [31:0] lo_o);
    bus.op = op; bus.rs_val = a; bus.rt_val = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1; own = 0; busy_n = 0; hi_o = 32'hx; lo_o = 32'hx;
    for (int k = 1; k <= 60; k++) begin
      if (bus.alu_own) own++;
      if (bus.busy) busy_n++;
      if (bus.done) begin
        lat = k; hi_o = bus.hi; lo_o = bus.lo;
        break;
      end
      @(posedge clk); #1;
    end
    $display("op=%0d rs=%h rt=%h -> hi=%h lo=%h lat=%0d own=%0d", op, a, b, hi_o, lo_o, lat, own);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = 2'b00; bus.rs_val = '0; bus.rt_val = '0;
    rst_n = 1'b0;
    #22;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
    checks++; if (bus.alu_own !== 1'b0) begin errors++; $display("FAIL reset_alu_own got %b exp 0", bus.alu_own); end
    checks++; if (bus.alu_a !== 32'h0) begin errors++; $display("FAIL reset_alu_a got %h exp 0", bus.alu_a); end
    checks++; if (bus.alu_b !== 32'h0) begin errors++; $display("FAIL reset_alu_b got %h exp 0", bus.alu_b); end
    checks++; if (bus.alu_control !== 3'b000) begin errors++; $display("FAIL reset_alu_ctl got %b exp 000", bus.alu_control); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h exp 0", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h exp 0", bus.lo); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mult();
    int lat, own, bn; logic [31:0] h, l;
    run_op(2'b00, 32'h7, 32'hFFFFFFFD, lat, own, bn, h, l);
    checks++; if (lat !== 35) begin errors++; $display("FAIL mult_latency got %0d exp 35", lat); end
    checks++; if (own !== 32) begin errors++; $display("FAIL mult_alu_own_cycles got %0d exp 32", own); end
    checks++; if (bn !== 35) begin errors++; $display("FAIL mult_busy_cycles got %0d exp 35", bn); end
    checks++; if (h !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h exp FFFFFFFF", h); end
    checks++; if (l !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_lo got %h exp FFFFFFEB", l); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse got %b exp 0", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mult_idle_busy got %b exp 0", bus.busy); end
    run_op(2'b00, 32'h80000000, 32'hFFFFFFFF, lat, own, bn, h, l);
    checks++; if (h !== 32'h0) begin errors++; $display("FAIL mult_min_hi got %h exp 0", h); end
    checks++; if (l !== 32'h80000000) begin errors++; $display("FAIL mult_min_lo got %h exp 80000000", l); end
    run_op(2'b00, 32'hFFFFFFFF, 32'h6, lat, own, bn, h, l);
    checks++; if (h !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_neg6_hi got %h exp FFFFFFFF", h); end
    checks++; if (l !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_neg6_lo got %h exp FFFFFFFA", l); end
  endtask

  task automatic test_multu();
    int lat, own, bn; logic [31:0] h, l;
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, own, bn, h, l);
    checks++; if (h !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_max_hi got %h exp FFFFFFFE", h); end
    checks++; if (l !== 32'h00000001) begin errors++; $display("FAIL multu_max_lo got %h exp 00000001", l); end
    checks++; if (lat !== 35) begin errors++; $display("FAIL multu_latency got %0d exp 35", lat); end
    run_op(2'b01, 32'h6, 32'hFFFFFFFF, lat, own, bn, h, l);
    checks++; if (h !== 32'h5) begin errors++; $display("FAIL multu_6_hi got %h exp 5", h); end
    checks++; if (l !== 32'hFFFFFFFA) begin errors++; $display("FAIL multu_6_lo got %h exp FFFFFFFA", l); end
  endtask

  task automatic test_div();
    int lat, own, bn; logic [31:0] h, l;
`ifdef MULDIV_DIV_EN
    run_op(2'b10, 32'hFFFFFFF9, 32'h2, lat, own, bn, h, l);
    checks++; if (lat !== 35) begin errors++; $display("FAIL div_latency got %0d exp 35", lat); end
    checks++; if (own !== 32) begin errors++; $display("FAIL div_alu_own_cycles got %0d exp 32", own); end
    checks++; if (l !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_neg7_lo got %h exp FFFFFFFD", l); end
    checks++; if (h !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_neg7_hi got %h exp FFFFFFFF", h); end
    run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, lat, own, bn, h, l);
    checks++; if (l !== 32'h0) begin errors++; $display("FAIL divu_big_lo got %h exp 0", l); end
    checks++; if (h !== 32'h80000000) begin errors++; $display("FAIL divu_big_hi got %h exp 80000000", h); end
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, lat, own, bn, h, l);
    checks++; if (l !== 32'h80000000) begin errors++; $display("FAIL div_intmin_lo got %h exp 80000000", l); end
    checks++; if (h !== 32'h0) begin errors++; $display("FAIL div_intmin_hi got %h exp 0", h); end
    run_op(2'b10, 32'h7, 32'hFFFFFFFE, lat, own, bn, h, l);
    checks++; if (l !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_7_neg2_lo got %h exp FFFFFFFD", l); end
    checks++; if (h !== 32'h1) begin errors++; $display("FAIL div_7_neg2_hi got %h exp 1", h); end
    run_op(2'b11, 32'd100, 32'd7, lat, own, bn, h, l);
    checks++; if (l !== 32'd14) begin errors++; $display("FAIL divu_100_7_lo got %h exp e", l); end
    checks++; if (h !== 32'd2) begin errors++; $display("FAIL divu_100_7_hi got %h exp 2", h); end
`else
    run_op(2'b10, 32'h10, 32'h2, lat, own, bn, h, l);
    checks++; if (lat !== 1) begin errors++; $display("FAIL nodiv_latency got %0d exp 1", lat); end
    checks++; if (own !== 0) begin errors++; $display("FAIL nodiv_alu_own_cycles got %0d exp 0", own); end
    checks++; if (h !== 32'h0) begin errors++; $display("FAIL nodiv_hi got %h exp 0", h); end
    checks++; if (l !== 32'h0) begin errors++; $display("FAIL nodiv_lo got %h exp 0", l); end
`endif
  endtask

  task automatic test_div_zero();
    int lat, own, bn; logic [31:0] h, l;
`ifdef MULDIV_DIV_EN
    run_op(2'b11, 32'h1234, 32'h0, lat, own, bn, h, l);
    checks++; if (lat !== 2) begin errors++; $display("FAIL divz_latency got %0d exp 2", lat); end
    checks++; if (bn !== 2) begin errors++; $display("FAIL divz_busy_cycles got %0d exp 2", bn); end
    checks++; if (own !== 0) begin errors++; $display("FAIL divz_alu_own_cycles got %0d exp 0", own); end
    checks++; if (l !== 32'hFFFFFFFF) begin errors++; $display("FAIL divz_lo got %h exp FFFFFFFF", l); end
    checks++; if (h !== 32'h1234) begin errors++; $display("FAIL divz_hi got %h exp 1234", h); end
    run_op(2'b10, 32'hFFFFFF00, 32'h0, lat, own, bn, h, l);
    checks++; if (h !== 32'hFFFFFF00) begin errors++; $display("FAIL divz_signed_hi got %h exp FFFFFF00", h); end
`else
    run_op(2'b01, 32'h3, 32'h5, lat, own, bn, h, l);
    checks++; if (l !== 32'hF) begin errors++; $display("FAIL nodivz_pre_lo got %h exp f", l); end
    run_op(2'b11, 32'h1234, 32'h0, lat, own, bn, h, l);
    checks++; if (lat !== 1) begin errors++; $display("FAIL nodivz_latency got %0d exp 1", lat); end
    checks++; if (l !== 32'h0) begin errors++; $display("FAIL nodivz_lo got %h exp 0", l); end
`endif
  endtask

  task automatic test_flush();
    int lat, own, bn; logic [31:0] h, l;
    logic done_seen, own_mid, busy_end;
    int late_busy;
    run_op(2'b01, 32'h6, 32'hFFFFFFFF, lat, own, bn, h, l);  // hi=5, lo=FFFFFFFA
    bus.op = 2'b00; bus.rs_val = 32'h7; bus.rt_val = 32'h3; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    done_seen = 1'b0; own_mid = 1'b0; busy_end = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      if (bus.done) done_seen = 1'b1;
      if (k == 9) own_mid = bus.alu_own;
      if (k == 11) busy_end = bus.busy;
      bus.start = (k == 8);   // ignored, mid-RUN
      bus.flush = (k == 10);  // abort, back to IDLE after this edge
      if (k < 11) begin @(posedge clk); #1; end
    end
    $display("flush mid-RUN: busy=%b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
    checks++; if (own_mid !== 1'b1) begin errors++; $display("FAIL flush_own_mid got %b exp 1", own_mid); end
    checks++; if (busy_end !== 1'b0) begin errors++; $display("FAIL flush_busy got %b exp 0", busy_end); end
    checks++; if (done_seen !== 1'b0) begin errors++; $display("FAIL flush_done_seen got %b exp 0", done_seen); end
    checks++; if (bus.hi !== 32'h5) begin errors++; $display("FAIL flush_hi got %h exp 5", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL flush_lo got %h exp FFFFFFFA", bus.lo); end
    late_busy = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.busy || bus.done) late_busy++;
      @(posedge clk); #1;
    end
    checks++; if (late_busy !== 0) begin errors++; $display("FAIL ignored_start_queued got %0d exp 0", late_busy); end
    // start and flush together in IDLE: not accepted
    bus.start = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    $display("start+flush in IDLE: busy=%b", bus.busy);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL start_flush_busy got %b exp 0", bus.busy); end
    // flush during DONE does not undo the committed result
    bus.op = 2'b01; bus.rs_val = 32'h3; bus.rt_val = 32'h4; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 35; k++) begin
      bus.flush = (k == 35);
      if (k < 35) begin @(posedge clk); #1; end
    end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL flush_in_done_pulse got %b exp 1", bus.done); end
    @(posedge clk); #1;
    bus.flush = 1'b0;
    $display("flush in DONE: hi=%h lo=%h busy=%b", bus.hi, bus.lo, bus.busy);
    checks++; if (bus.lo !== 32'hC) begin errors++; $display("FAIL flush_in_done_lo got %h exp c", bus.lo); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL flush_in_done_hi got %h exp 0", bus.hi); end
  endtask

  task automatic test_back_to_back();
    int lat, own, bn; logic [31:0] h, l;
    run_op(2'b01, 32'h3, 32'h5, lat, own, bn, h, l);
    checks++; if (l !== 32'hF) begin errors++; $display("FAIL b2b_first_lo got %h exp f", l); end
    run_op(2'b00, 32'hFFFFFFFE, 32'hFFFFFFFE, lat, own, bn, h, l);
    checks++; if (lat !== 35) begin errors++; $display("FAIL b2b_second_latency got %0d exp 35", lat); end
    checks++; if (l !== 32'h4) begin errors++; $display("FAIL b2b_second_lo got %h exp 4", l); end
    checks++; if (h !== 32'h0) begin errors++; $display("FAIL b2b_second_hi got %h exp 0", h); end
  endtask

  task automatic test_reset_mid();
    logic own20;
    bus.op = 2'b00; bus.rs_val = 32'h7; bus.rt_val = 32'h3; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k < 20; k++) begin @(posedge clk); #1; end
    own20 = bus.alu_own;
    #2 rst_n = 1'b0;
    #1;
    $display("reset mid-RUN: busy=%b own=%b ctl=%b hi=%h lo=%h", bus.busy, bus.alu_own, bus.alu_control, bus.hi, bus.lo);
    checks++; if (own20 !== 1'b1) begin errors++; $display("FAIL rstmid_own_before got %b exp 1", own20); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", bus.busy); end
    checks++; if (bus.alu_own !== 1'b0) begin errors++; $display("FAIL rstmid_alu_own got %b exp 0", bus.alu_own); end
    checks++; if (bus.alu_control !== 3'b000) begin errors++; $display("FAIL rstmid_alu_ctl got %b exp 000", bus.alu_control); end
    checks++; if (bus.alu_b !== 32'h0) begin errors++; $display("FAIL rstmid_alu_b got %h exp 0", bus.alu_b); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL rstmid_lo got %h exp 0", bus.lo); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b exp 0", bus.done); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_after_busy got %b exp 0", bus.busy); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_div_zero();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule
